// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, WB/LD write ports, and a load busy scoreboard.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.

module regfile_rd_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] rf,
  input  logic [DEPTH-1:0]             bsy,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                         we0,
  input  logic [ADDR_W-1:0]            wa0,
  input  logic [DATA_W-1:0]            wd0,
  input  logic                         we1,
  input  logic [ADDR_W-1:0]            wa1,
  input  logic [DATA_W-1:0]            wd1,
`endif
  output logic [DATA_W-1:0]            data,
  output logic                         busy
);
  always_comb begin
    data = rf[addr];
    busy = bsy[addr];
`ifdef REGFILE_BYPASS_EN
    // LD port is checked last so it takes priority over WB
    if (we0 && wa0 == addr) begin data = wd0; busy = 1'b0; end
    if (we1 && wa1 == addr) begin data = wd1; busy = 1'b0; end
`endif
    // forwarding must not leak through while held in reset or at r0
    if (addr == '0 || !rst_n) begin data = '0; busy = 1'b0; end
  end
endmodule

module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     RegWre0,
  input  logic [ADDR_W-1:0]        WriteReg0,
  input  logic [DATA_W-1:0]        WriteData0,
  input  logic                     RegWre1,
  input  logic [ADDR_W-1:0]        WriteReg1,
  input  logic [DATA_W-1:0]        WriteData1,
  input  logic [NUM_RD*ADDR_W-1:0] ReadReg,
  output logic [NUM_RD*DATA_W-1:0] ReadData,
  input  logic                     Reserve,
  input  logic [ADDR_W-1:0]        ReserveReg,
  output logic [NUM_RD-1:0]        Busy
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:1][DATA_W-1:0] regs_q;
  logic [DEPTH-1:1]             busy_q;
  logic [DEPTH-1:0][DATA_W-1:0] rf;
  logic [DEPTH-1:0]             bsy;

  // r0 has no storage; it is a constant zero slot in the read view
  assign rf  = {regs_q, {DATA_W{1'b0}}};
  assign bsy = {busy_q, 1'b0};

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (RegWre1 && WriteReg1 == ADDR_W'(r))      regs_q[r] <= WriteData1;
        else if (RegWre0 && WriteReg0 == ADDR_W'(r)) regs_q[r] <= WriteData0;
        // a new reserve outranks the clear from a completing write
        if (Reserve && ReserveReg == ADDR_W'(r))
          busy_q[r] <= 1'b1;
        else if ((RegWre0 && WriteReg0 == ADDR_W'(r)) || (RegWre1 && WriteReg1 == ADDR_W'(r)))
          busy_q[r] <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd (
      .rf    (rf),
      .bsy   (bsy),
      .rst_n (Reset),
      .addr  (ReadReg[i*ADDR_W +: ADDR_W]),
`ifdef REGFILE_BYPASS_EN
      .we0   (RegWre0),
      .wa0   (WriteReg0),
      .wd0   (WriteData0),
      .we1   (RegWre1),
      .wa1   (WriteReg1),
      .wd1   (WriteData1),
`endif
      .data  (ReadData[i*DATA_W +: DATA_W]),
      .busy  (Busy[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table on a 2-port/32-bit instance plus reset and 4-port sequences.
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK, Reset;
  logic        we0, we1, rsv;
  logic [4:0]  wa0, wa1, rr;
  logic [31:0] wd0, wd1;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  busy;

  logic        w_we0, w_we1, w_rsv;
  logic [2:0]  w_wa0, w_wa1, w_rr;
  logic [15:0] w_wd0, w_wd1;
  logic [11:0] w_ra;
  logic [63:0] w_rd;
  logic [3:0]  w_busy;

  int n_chk = 0;
  int n_fail = 0;

  regfile_mp dut (
    .CLK(CLK), .Reset(Reset),
    .RegWre0(we0), .WriteReg0(wa0), .WriteData0(wd0),
    .RegWre1(we1), .WriteReg1(wa1), .WriteData1(wd1),
    .ReadReg(ra), .ReadData(rd),
    .Reserve(rsv), .ReserveReg(rr), .Busy(busy)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dut_w (
    .CLK(CLK), .Reset(Reset),
    .RegWre0(w_we0), .WriteReg0(w_wa0), .WriteData0(w_wd0),
    .RegWre1(w_we1), .WriteReg1(w_wa1), .WriteData1(w_wd1),
    .ReadReg(w_ra), .ReadData(w_rd),
    .Reserve(w_rsv), .ReserveReg(w_rr), .Busy(w_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic we0; logic [4:0] wa0; logic [31:0] wd0;
    logic we1; logic [4:0] wa1; logic [31:0] wd1;
    logic rsv; logic [4:0] rr;
    logic [4:0] ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0] eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic a_we0, logic [4:0] a_wa0, logic [31:0] a_wd0,
                              logic a_we1, logic [4:0] a_wa1, logic [31:0] a_wd1,
                              logic a_rsv, logic [4:0] a_rr, logic [4:0] a_ra0, logic [4:0] a_ra1,
                              logic [31:0] a_e0, logic [31:0] a_e1, logic [1:0] a_eb);
    vec_t v;
    v.we0 = a_we0; v.wa0 = a_wa0; v.wd0 = a_wd0;
    v.we1 = a_we1; v.wa1 = a_wa1; v.wd1 = a_wd1;
    v.rsv = a_rsv; v.rr = a_rr; v.ra0 = a_ra0; v.ra1 = a_ra1;
    v.e0 = a_e0; v.e1 = a_e1; v.eb = a_eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_main();
    we0 = 0; wa0 = 0; wd0 = 0; we1 = 0; wa1 = 0; wd1 = 0; rsv = 0; rr = 0;
  endtask

  task automatic idle_wide();
    w_we0 = 0; w_wa0 = 0; w_wd0 = 0; w_we1 = 0; w_wa1 = 0; w_wd1 = 0; w_rsv = 0; w_rr = 0;
  endtask

  initial begin
    logic [11:0] sets [3];
    logic [2:0]  a;
    Reset = 1'b0;
    idle_main(); ra = '0;
    idle_wide(); w_ra = '0;

    // reset state
    @(negedge CLK);
    ra = {5'd5, 5'd3};
    #2;
    chk("reset rd", rd, 64'h0);
    chk("reset busy", {62'h0, busy}, 64'h0);
    @(negedge CLK);
    Reset = 1'b1;

    //           we0 wa0 wd0            we1 wa1 wd1            rsv rr  ra0 ra1 e0 e1 eb
    tbl.push_back(mk(0,  0, 0,            0,  0, 0,            0,  0,  0,  5, 0, 0, 2'b00));
    tbl.push_back(mk(1,  5, 32'hDEADBEEF, 0,  0, 0,            0,  0,  0,  5, 0, BYP ? 32'hDEADBEEF : 32'h0, 2'b00));
    tbl.push_back(mk(0,  0, 0,            0,  0, 0,            0,  0,  0,  5, 0, 32'hDEADBEEF, 2'b00));
    tbl.push_back(mk(1,  0, 32'h1234,     1,  0, 32'h1234,     1,  0,  0,  0, 0, 0, 2'b00));
    tbl.push_back(mk(0,  0, 0,            0,  0, 0,            0,  0,  0,  0, 0, 0, 2'b00));
    tbl.push_back(mk(1,  7, 32'hAAAA0000, 1,  7, 32'h5555FFFF, 0,  0,  7,  0, BYP ? 32'h5555FFFF : 32'h0, 0, 2'b00));
    tbl.push_back(mk(0,  0, 0,            0,  0, 0,            0,  0,  7,  0, 32'h5555FFFF, 0, 2'b00));
    tbl.push_back(mk(0,  0, 0,            0,  0, 0,            1,  3,  3,  0, 0, 0, 2'b00));
    tbl.push_back(mk(0,  0, 0,            0,  0, 0,            0,  0,  3,  0, 0, 0, 2'b01));
    tbl.push_back(mk(0,  0, 0,            1,  3, 32'h42,       0,  0,  3,  0, BYP ? 32'h42 : 32'h0, 0, BYP ? 2'b00 : 2'b01));
    tbl.push_back(mk(0,  0, 0,            0,  0, 0,            0,  0,  3,  0, 32'h42, 0, 2'b00));
    tbl.push_back(mk(0,  0, 0,            0,  0, 0,            1,  3,  3,  0, 32'h42, 0, 2'b00));
    tbl.push_back(mk(0,  0, 0,            1,  3, 32'h43,       1,  3,  3,  0, BYP ? 32'h43 : 32'h42, 0, BYP ? 2'b00 : 2'b01));
    tbl.push_back(mk(0,  0, 0,            0,  0, 0,            0,  0,  3,  3, 32'h43, 32'h43, 2'b11));
    tbl.push_back(mk(1,  9, 32'h11,       0,  0, 0,            0,  0,  0,  9, 0, BYP ? 32'h11 : 32'h0, 2'b00));
    tbl.push_back(mk(1,  9, 32'h22,       0,  0, 0,            0,  0,  0,  9, 0, BYP ? 32'h22 : 32'h11, 2'b00));
    tbl.push_back(mk(0,  0, 0,            0,  0, 0,            0,  0,  0,  9, 0, 32'h22, 2'b00));
    tbl.push_back(mk(1, 10, 32'hA,        1, 11, 32'hB,        0,  0, 10, 11, BYP ? 32'hA : 32'h0, BYP ? 32'hB : 32'h0, 2'b00));
    tbl.push_back(mk(0,  0, 0,            0,  0, 0,            0,  0, 10, 11, 32'hA, 32'hB, 2'b00));
    tbl.push_back(mk(1, 31, 32'hFFFFFFFF, 0,  0, 0,            1, 31, 31,  3, BYP ? 32'hFFFFFFFF : 32'h0, 32'h43, 2'b10));
    tbl.push_back(mk(0,  0, 0,            0,  0, 0,            0,  0, 31,  5, 32'hFFFFFFFF, 32'hDEADBEEF, 2'b01));

    foreach (tbl[i]) begin
      @(negedge CLK);
      we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
      we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
      rsv = tbl[i].rsv; rr = tbl[i].rr;
      ra = {tbl[i].ra1, tbl[i].ra0};
      #2;
      chk($sformatf("vec%0d data0", i), {32'h0, rd[31:0]}, {32'h0, tbl[i].e0});
      chk($sformatf("vec%0d data1", i), {32'h0, rd[63:32]}, {32'h0, tbl[i].e1});
      chk($sformatf("vec%0d busy", i), {62'h0, busy}, {62'h0, tbl[i].eb});
    end

    // mid-cycle reset with a write pending: outputs drop at once, write is lost
    @(negedge CLK);
    idle_main();
    we0 = 1; wa0 = 5'd12; wd0 = 32'h99;
    ra = {5'd5, 5'd3};
    #2;
    chk("pre-reset r5", {32'h0, rd[63:32]}, 64'hDEADBEEF);
    Reset = 1'b0;
    #1;
    chk("mid-reset rd", rd, 64'h0);
    chk("mid-reset busy", {62'h0, busy}, 64'h0);
    @(posedge CLK);
    #1;
    we0 = 0;
    Reset = 1'b1;
    @(negedge CLK);
    ra = {5'd3, 5'd12};
    #2;
    chk("discarded write r12", {32'h0, rd[31:0]}, 64'h0);
    chk("cleared busy r3", {62'h0, busy}, 64'h0);
    chk("cleared r3", {32'h0, rd[63:32]}, 64'h0);

    // first write after reset release lands
    @(negedge CLK);
    we0 = 1; wa0 = 5'd12; wd0 = 32'h77;
    @(negedge CLK);
    idle_main();
    #2;
    chk("post-reset write r12", {32'h0, rd[31:0]}, 64'h77);

    // 4-port instance: distinct contents, no cross-port aliasing
    for (int i = 1; i <= 7; i += 2) begin
      @(negedge CLK);
      w_we0 = 1; w_wa0 = 3'(i); w_wd0 = 16'(16'h1111 * i);
      w_we1 = (i < 7); w_wa1 = 3'(i + 1); w_wd1 = 16'(16'h1111 * (i + 1));
    end
    @(negedge CLK);
    idle_wide();
    sets[0] = {3'd7, 3'd5, 3'd3, 3'd1};
    sets[1] = {3'd1, 3'd6, 3'd4, 3'd2};
    sets[2] = {3'd2, 3'd6, 3'd7, 3'd0};
    for (int s = 0; s < 3; s++) begin
      @(negedge CLK);
      w_ra = sets[s];
      #2;
      for (int p = 0; p < 4; p++) begin
        a = w_ra[p*3 +: 3];
        chk($sformatf("wide set%0d port%0d", s, p), {48'h0, w_rd[p*16 +: 16]},
            {48'h0, (a == 3'd0) ? 16'h0 : 16'(16'h1111 * a)});
      end
    end
    @(negedge CLK);
    w_rsv = 1; w_rr = 3'd6;
    @(negedge CLK);
    idle_wide();
    w_ra = {3'd0, 3'd6, 3'd6, 3'd1};
    #2;
    chk("wide busy", {60'h0, w_busy}, {60'h0, 4'b0110});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
